// File: rtl/sk6812_strip_ctrl.sv
`default_nettype none
// ============================================================================
// sk6812_strip_ctrl : register-mapped pixel buffer that streams frames into an
// sk6812rgbw driver. Optional SK6812_STRIP_BRIGHTNESS_EN adds BRIGHT. Rev 1.0
// ============================================================================
module sk6812_strip_ctrl #(
   parameter int NUM_PIXELS = 16
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_cs,
   input  logic        i_we,
   input  logic [2:0]  i_addr,
   input  logic [7:0]  i_wdata,
   output logic [7:0]  o_rdata,
   output logic        o_irq,
   output logic        o_led_strb,
   output logic [31:0] o_led_color,
   output logic        o_reset_strb,
   input  logic        i_drv_busy
);
   localparam int         IW       = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam logic [7:0] NPIX     = 8'(NUM_PIXELS);
   localparam logic [7:0] LAST_IDX = 8'(NUM_PIXELS - 1);

   localparam logic [2:0] A_INDEX  = 3'd0;
   localparam logic [2:0] A_COLOR0 = 3'd1;
   localparam logic [2:0] A_COLOR1 = 3'd2;
   localparam logic [2:0] A_COLOR2 = 3'd3;
   localparam logic [2:0] A_COLOR3 = 3'd4;
   localparam logic [2:0] A_CTRL   = 3'd5;
   localparam logic [2:0] A_LENGTH = 3'd6;
   localparam logic [2:0] A_BRIGHT = 3'd7;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LOAD       = 3'd1,
      STROBE     = 3'd2,
      ACK        = 3'd3,
      DRAIN      = 3'd4,
      LATCH      = 3'd5,
      LATCH_ACK  = 3'd6,
      LATCH_WAIT = 3'd7
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  index;
   logic [7:0]  length;
   logic [7:0]  pix;
   logic [7:0]  stage0;
   logic [7:0]  stage1;
   logic [7:0]  stage2;
   logic [7:0]  stage3;
   logic [31:0] pix_buf [NUM_PIXELS];
   logic        pending;
   logic [7:0]  bright;
   logic [31:0] raw_word;
   logic [31:0] load_word;

   logic wr;
   logic ctrl_wr;
   logic show_wr;
   logic abort_wr;
   logic irqclr_wr;
   logic active;
   logic in_frame;
   logic last_pix;

   logic strb_nxt;
   logic rst_strb_nxt;
   logic load_en;
   logic pix_clr;
   logic pix_inc;
   logic irq_set;
   logic pend_clr;

   assign wr        = i_cs & i_we;
   assign ctrl_wr   = wr & (i_addr == A_CTRL);
   assign show_wr   = ctrl_wr & i_wdata[0];
   assign abort_wr  = ctrl_wr & i_wdata[1];
   assign irqclr_wr = ctrl_wr & i_wdata[2];
   assign active    = (state != IDLE);
   assign in_frame  = (state == LOAD) || (state == STROBE) ||
                      (state == ACK)  || (state == DRAIN);
   // Inequality rather than equality so a LENGTH shrink below p+1 still ends the frame.
   assign last_pix  = (({1'b0, pix} + 9'd1) >= {1'b0, length});
   assign raw_word  = pix_buf[pix[IW-1:0]];

   // ------------------------------------------------------------------------
   // Register file and pixel buffer
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         index  <= 8'd0;
         length <= NPIX;
         stage0 <= 8'd0;
         stage1 <= 8'd0;
         stage2 <= 8'd0;
         stage3 <= 8'd0;
         for (int i = 0; i < NUM_PIXELS; i++) begin
            pix_buf[i] <= 32'd0;
         end
      end else if (wr) begin
         case (i_addr)
            A_INDEX: begin
               if (i_wdata < NPIX) begin
                  index <= i_wdata;
               end
            end
            A_COLOR0: stage0 <= i_wdata;
            A_COLOR1: stage1 <= i_wdata;
            A_COLOR2: stage2 <= i_wdata;
            A_COLOR3: begin
               stage3                 <= i_wdata;
               pix_buf[index[IW-1:0]] <= {stage0, stage1, stage2, i_wdata};
               index                  <= (index == LAST_IDX) ? 8'd0 : index + 8'd1;
            end
            A_LENGTH: begin
               if ((i_wdata != 8'd0) && (i_wdata <= NPIX)) begin
                  length <= i_wdata;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SK6812_STRIP_BRIGHTNESS_EN
   function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
      logic [15:0] prod;
      prod = {8'd0, c} * ({8'd0, b} + 16'd1);
      return 8'(prod >> 8);
   endfunction

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         bright <= 8'hFF;
      end else if (wr && (i_addr == A_BRIGHT)) begin
         bright <= i_wdata;
      end
   end

   assign load_word = {scale8(raw_word[31:24], bright), scale8(raw_word[23:16], bright),
                       scale8(raw_word[15:8],  bright), scale8(raw_word[7:0],   bright)};
`else
   assign bright    = 8'hFF;
   assign load_word = raw_word;
`endif

   always_comb begin
      o_rdata = 8'h00;
      case (i_addr)
         A_INDEX:  o_rdata = index;
         A_COLOR0: o_rdata = stage0;
         A_COLOR1: o_rdata = stage1;
         A_COLOR2: o_rdata = stage2;
         A_COLOR3: o_rdata = stage3;
         A_CTRL:   o_rdata = {5'b0, pending, o_irq, active};
         A_LENGTH: o_rdata = length;
         A_BRIGHT: o_rdata = bright;
         default:  o_rdata = 8'h00;
      endcase
   end

   // ------------------------------------------------------------------------
   // Frame sequencer
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state        <= IDLE;
         pix          <= 8'd0;
         pending      <= 1'b0;
         o_irq        <= 1'b0;
         o_led_strb   <= 1'b0;
         o_reset_strb <= 1'b0;
         o_led_color  <= 32'd0;
      end else begin
         state        <= state_nxt;
         o_led_strb   <= strb_nxt;
         o_reset_strb <= rst_strb_nxt;
         if (load_en) begin
            o_led_color <= load_word;
         end
         if (pix_clr) begin
            pix <= 8'd0;
         end else if (pix_inc) begin
            pix <= pix + 8'd1;
         end
         if (irq_set) begin
            o_irq <= 1'b1;
         end else if (irqclr_wr) begin
            o_irq <= 1'b0;
         end
         if (abort_wr && active) begin
            pending <= 1'b0;
         end else if (pend_clr) begin
            pending <= 1'b0;
         end else if (show_wr && active) begin
            pending <= 1'b1;
         end
      end
   end

   // Strobes are registered, so each one is requested the cycle before it
   // appears; busy only rises in response to our own strobes, so a low busy
   // seen now is still low when the pulse is on the wire.
   always_comb begin
      state_nxt    = state;
      strb_nxt     = 1'b0;
      rst_strb_nxt = 1'b0;
      load_en      = 1'b0;
      pix_clr      = 1'b0;
      pix_inc      = 1'b0;
      irq_set      = 1'b0;
      pend_clr     = 1'b0;

      case (state)
         IDLE: begin
            if (show_wr && !abort_wr) begin
               state_nxt = LOAD;
               pix_clr   = 1'b1;
            end
         end
         LOAD: begin
            load_en   = 1'b1;
            state_nxt = STROBE;
            strb_nxt  = !i_drv_busy;
         end
         STROBE: begin
            if (o_led_strb) begin
               state_nxt = ACK;
            end else begin
               strb_nxt = !i_drv_busy;
            end
         end
         ACK: state_nxt = DRAIN;
         DRAIN: begin
            if (!i_drv_busy) begin
               if (last_pix) begin
                  state_nxt    = LATCH;
                  rst_strb_nxt = 1'b1;
               end else begin
                  state_nxt = LOAD;
                  pix_inc   = 1'b1;
               end
            end
         end
         LATCH: begin
            if (o_reset_strb) begin
               state_nxt = LATCH_ACK;
            end else begin
               rst_strb_nxt = !i_drv_busy && !o_led_strb;
            end
         end
         LATCH_ACK: state_nxt = LATCH_WAIT;
         LATCH_WAIT: begin
            if (!i_drv_busy) begin
               irq_set = 1'b1;
               if (!abort_wr && (pending || show_wr)) begin
                  state_nxt = LOAD;
                  pix_clr   = 1'b1;
                  pend_clr  = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A pixel strobe already on the wire makes the driver busy next cycle,
      // so the latch must not be requested in the same cycle as that strobe.
      if (abort_wr && in_frame) begin
         state_nxt    = LATCH;
         strb_nxt     = 1'b0;
         load_en      = 1'b0;
         pix_clr      = 1'b0;
         pix_inc      = 1'b0;
         rst_strb_nxt = !i_drv_busy && !o_led_strb;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sk6812_strip_ctrl.sv
`default_nettype none
// tb_sk6812_strip_ctrl : randomized frame bench with a busy-driver model and a
// register/buffer reference model.
module tb_sk6812_strip_ctrl;
   localparam int NP         = 16;
   localparam int LATCH_BUSY = 20;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cs;
   logic        we;
   logic [2:0]  addr;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        irq;
   logic        led_strb;
   logic [31:0] led_color;
   logic        reset_strb;
   logic        drv_busy;

   logic        force_busy;
   int          pix_busy;
   int          busy_cnt   = 0;
   logic        strb_d     = 1'b0;
   logic        rst_d      = 1'b0;
   int          latch_cnt  = 0;
   int          proto_err  = 0;
   logic [31:0] strb_q [$];

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] m_buf [NP];
   logic [7:0]  m_stage0, m_stage1, m_stage2, m_stage3;
   int          m_index;
   int          m_len;
   int          m_bright;

   always #5 clk = ~clk;

   assign drv_busy = (busy_cnt != 0) || force_busy;

   sk6812_strip_ctrl #(.NUM_PIXELS(NP)) dut (
      .i_clk        (clk),
      .i_reset_n    (rst_n),
      .i_cs         (cs),
      .i_we         (we),
      .i_addr       (addr),
      .i_wdata      (wdata),
      .o_rdata      (rdata),
      .o_irq        (irq),
      .o_led_strb   (led_strb),
      .o_led_color  (led_color),
      .o_reset_strb (reset_strb),
      .i_drv_busy   (drv_busy)
   );

   // Driver model: busy rises the cycle after a strobe and holds for a set time.
   always @(posedge clk) begin
      if ((led_strb && strb_d) || (reset_strb && rst_d)) proto_err++;
      if ((led_strb || reset_strb) && drv_busy) proto_err++;
      if (led_strb) begin
         strb_q.push_back(led_color);
         busy_cnt <= pix_busy;
      end else if (reset_strb) begin
         latch_cnt++;
         busy_cnt <= LATCH_BUSY;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
      end
      strb_d <= led_strb;
      rst_d  <= reset_strb;
   end

   function automatic logic [7:0] mscale(input logic [7:0] c);
      int v;
      v = (int'(c) * (m_bright + 1)) / 256;
      return 8'(v);
   endfunction

   function automatic logic [31:0] expect_px(input int i);
      logic [31:0] w;
      w = m_buf[i];
      return {mscale(w[31:24]), mscale(w[23:16]), mscale(w[15:8]), mscale(w[7:0])};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NP; i++) m_buf[i] = 32'd0;
      m_stage0 = 8'd0; m_stage1 = 8'd0; m_stage2 = 8'd0; m_stage3 = 8'd0;
      m_index  = 0;
      m_len    = NP;
      m_bright = 255;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
      case (a)
         3'd0: if (int'(d) < NP) m_index = int'(d);
         3'd1: m_stage0 = d;
         3'd2: m_stage1 = d;
         3'd3: m_stage2 = d;
         3'd4: begin
            m_buf[m_index] = {m_stage0, m_stage1, m_stage2, d};
            m_stage3       = d;
            m_index        = (m_index + 1) % NP;
         end
         3'd6: if ((d != 8'd0) && (int'(d) <= NP)) m_len = int'(d);
`ifdef SK6812_STRIP_BRIGHTNESS_EN
         3'd7: m_bright = int'(d);
`endif
         default: ;
      endcase
   endtask

   task automatic rd(input logic [2:0] a, output logic [7:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic write_pixel(input logic [31:0] px);
      wr(3'd1, px[31:24]);
      wr(3'd2, px[23:16]);
      wr(3'd3, px[15:8]);
      wr(3'd4, px[7:0]);
   endtask

   task automatic wait_idle(input string tag);
      logic [7:0] c;
      int n;
      n = 0;
      rd(3'd5, c);
      while ((c[0] || c[2]) && n < 4000) begin
         @(negedge clk);
         rd(3'd5, c);
         n++;
      end
      check({tag, " idle within budget"}, 32'(n < 4000), 32'd1);
   endtask

   task automatic wait_strobes(input int target, input string tag);
      int n;
      n = 0;
      while (strb_q.size() < target && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check({tag, " strobe within budget"}, 32'(n < 4000), 32'd1);
   endtask

   task automatic frame_check(input string tag, input int s0, input int l0,
                              input int nframes, input int len);
      check({tag, " strobes"}, 32'(strb_q.size() - s0), 32'(nframes * len));
      for (int f = 0; f < nframes; f++) begin
         for (int i = 0; i < len; i++) begin
            if (s0 + f * len + i < strb_q.size())
               check($sformatf("%s f%0d px%0d", tag, f, i), strb_q[s0 + f * len + i], expect_px(i));
         end
      end
      check({tag, " latches"}, 32'(latch_cnt - l0), 32'(nframes));
      check({tag, " irq"}, 32'(irq), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed no completion, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] c;
      int s0, l0, len;

      cs = 1'b0; we = 1'b0; addr = 3'd0; wdata = 8'd0;
      rst_n = 1'b0; force_busy = 1'b0; pix_busy = 40;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("reset irq", 32'(irq), 32'd0);
      check("reset led_strb", 32'(led_strb), 32'd0);
      check("reset reset_strb", 32'(reset_strb), 32'd0);
      check("reset led_color", led_color, 32'd0);
      rd(3'd0, c); check("reset INDEX", 32'(c), 32'd0);
      rd(3'd5, c); check("reset CTRL", 32'(c), 32'd0);
      rd(3'd6, c); check("reset LENGTH", 32'(c), 32'(NP));
      rd(3'd7, c); check("reset BRIGHT", 32'(c), 32'hFF);

      // Random buffer fill; the final commit at INDEX 15 must wrap to 0.
      wr(3'd0, 8'd0);
      for (int i = 0; i < NP; i++) write_pixel($urandom);
      rd(3'd0, c); check("INDEX wrap", 32'(c), 32'(m_index));

      wr(3'd0, 8'd2);
      write_pixel(32'h12345678);
      rd(3'd0, c); check("INDEX after commit", 32'(c), 32'd3);
      rd(3'd4, c); check("COLOR3 readback", 32'(c), 32'h78);
      rd(3'd2, c); check("COLOR1 readback", 32'(c), 32'h34);

      wr(3'd0, 8'd16);
      rd(3'd0, c); check("INDEX out of range ignored", 32'(c), 32'd3);
      wr(3'd6, 8'd0);
      wr(3'd6, 8'd17);
      rd(3'd6, c); check("LENGTH illegal ignored", 32'(c), 32'(NP));
`ifndef SK6812_STRIP_BRIGHTNESS_EN
      wr(3'd7, 8'h00);
      rd(3'd7, c); check("BRIGHT fixed", 32'(c), 32'hFF);
`endif

      // Three-pixel frame with latency checks.
      wr(3'd6, 8'd3);
      s0 = strb_q.size(); l0 = latch_cnt;
      wr(3'd5, 8'h01);
      rd(3'd5, c); check("active after SHOW", 32'(c[0]), 32'd1);
      @(negedge clk); #1;
      check("strobe at N+2", 32'(led_strb), 32'd1);
      check("first color", led_color, expect_px(0));
      wait_idle("len3");
      frame_check("len3", s0, l0, 1, 3);
      if (s0 + 2 < strb_q.size()) check("buf2 literal", strb_q[s0 + 2], 32'h12345678);
      rd(3'd5, c); check("CTRL after frame", 32'(c), 32'h02);
      wr(3'd5, 8'h04);
      check("irq cleared", 32'(irq), 32'd0);

      // Random lengths and driver bit times.
      for (int r = 0; r < 3; r++) begin
         len = $urandom_range(1, NP);
         pix_busy = $urandom_range(1, 30);
         wr(3'd6, 8'(len));
         s0 = strb_q.size(); l0 = latch_cnt;
         wr(3'd5, 8'h01);
         wait_idle($sformatf("rand%0d", r));
         frame_check($sformatf("rand%0d", r), s0, l0, 1, m_len);
         wr(3'd5, 8'h04);
      end

      // SHOW repeated during a frame queues exactly one more frame.
      pix_busy = 10;
      wr(3'd6, 8'd4);
      s0 = strb_q.size(); l0 = latch_cnt;
      wr(3'd5, 8'h01);
      repeat (5) @(negedge clk);
      wr(3'd5, 8'h01);
      wr(3'd5, 8'h01);
      rd(3'd5, c); check("pending set", 32'(c[2]), 32'd1);
      wait_idle("double");
      frame_check("double", s0, l0, 2, 4);
      wr(3'd5, 8'h04);

      // Commit to a not-yet-loaded pixel mid-frame.
      pix_busy = 20;
      wr(3'd6, 8'd12);
      s0 = strb_q.size(); l0 = latch_cnt;
      wr(3'd5, 8'h01);
      wait_strobes(s0 + 2, "midcommit");
      wr(3'd0, 8'd9);
      write_pixel($urandom);
      wait_idle("midcommit");
      frame_check("midcommit", s0, l0, 1, 12);
      wr(3'd5, 8'h04);

      // ABORT while pixel 1 of 16 is in flight.
      pix_busy = 40;
      wr(3'd6, 8'd16);
      s0 = strb_q.size(); l0 = latch_cnt;
      wr(3'd5, 8'h01);
      wait_strobes(s0 + 2, "abort");
      wr(3'd5, 8'h02);
      wait_idle("abort");
      frame_check("abort", s0, l0, 1, 2);
      wr(3'd5, 8'h04);

      // SHOW and ABORT together in IDLE start nothing.
      s0 = strb_q.size();
      wr(3'd5, 8'h03);
      repeat (10) @(negedge clk);
      check("show+abort no strobe", 32'(strb_q.size() - s0), 32'd0);
      rd(3'd5, c); check("show+abort CTRL", 32'(c), 32'd0);

      // Reset in the middle of a frame: no latch, registers back to defaults.
      wr(3'd6, 8'd5);
      s0 = strb_q.size(); l0 = latch_cnt;
      wr(3'd5, 8'h01);
      wait_strobes(s0 + 1, "midreset");
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (100) @(negedge clk);
      check("midreset no latch", 32'(latch_cnt - l0), 32'd0);
      check("midreset strobes", 32'(strb_q.size() - s0), 32'd1);
      check("midreset irq", 32'(irq), 32'd0);
      rd(3'd5, c); check("midreset CTRL", 32'(c), 32'd0);
      rd(3'd6, c); check("midreset LENGTH", 32'(c), 32'(NP));

      // Driver busy held high for 800 cycles: strobes must wait.
      force_busy = 1'b1;
      pix_busy = 8;
      wr(3'd6, 8'd2);
      wr(3'd0, 8'd0);
      write_pixel($urandom);
      write_pixel($urandom);
      s0 = strb_q.size(); l0 = latch_cnt;
      wr(3'd5, 8'h01);
      repeat (800) @(negedge clk);
      check("busy hold no strobe", 32'(strb_q.size() - s0), 32'd0);
      rd(3'd5, c); check("busy hold active", 32'(c[0]), 32'd1);
      force_busy = 1'b0;
      wait_idle("busyhold");
      frame_check("busyhold", s0, l0, 1, 2);
      wr(3'd5, 8'h04);

`ifdef SK6812_STRIP_BRIGHTNESS_EN
      wr(3'd7, 8'h7F);
      wr(3'd0, 8'd0);
      write_pixel(32'hFF80_4000);
      wr(3'd6, 8'd1);
      s0 = strb_q.size(); l0 = latch_cnt;
      wr(3'd5, 8'h01);
      wait_idle("bright");
      frame_check("bright", s0, l0, 1, 1);
      if (s0 < strb_q.size()) check("bright literal", strb_q[s0], 32'h7F40_2000);
`endif

      check("protocol violations", 32'(proto_err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
